// File: rtl/spaceinvaders_pkg.sv
// Types and constants shared by the space-invaders video blocks:
// bullet FSM states, screen size, RGB444 colour.
package spaceinvaders_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [11:0] rgb444_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b001,
      ST_FLYING   = 3'b010,
      ST_COOLDOWN = 3'b100
   } bullet_state_e;

   // Midpoint of two 10-bit columns, summed at 11 bits so it cannot overflow.
   function automatic logic [9:0] midpoint(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[10:1];
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector. reset_val_p = 1 makes a level held through reset
// look "already seen", so it does not produce a pulse on release.
module edge_detect #(
   parameter logic reset_val_p = 1'b1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic level_i,
   output logic rise_o
);

   logic prev_reg;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         prev_reg <= reset_val_p;
      end else begin
         prev_reg <= level_i;
      end
   end

   assign rise_o = level_i & ~prev_reg;

endmodule

// File: rtl/player_bullet.sv
// Player bullet: spawns at the player's centre on a shoot press, climbs one
// step per frame tick, then enforces a cooldown before the next shot.
module player_bullet
   import spaceinvaders_pkg::*;
#(
   parameter logic [9:0] start_y_p  = 10'd440,
   parameter logic [9:0] top_y_p    = 10'd16,
   parameter logic [9:0] speed_p    = 10'd4,
   parameter logic [3:0] cooldown_p = 4'd8,
   parameter rgb444_t    color_p    = 12'b1111_1111_0000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       frame_tick_i,
   input  logic       shoot_i,
   input  logic       alive_i,
   input  logic       freeze_i,
   input  logic [9:0] pos_left_i,
   input  logic [9:0] pos_right_i,
   input  logic       hit_enemy_i,
   output logic       bullet_active_o,
   output logic [9:0] bullet_x_o,
   output logic [9:0] bullet_y_o,
   output logic       shot_fired_o,
   output rgb444_t    color_o,
   output logic [2:0] state_o
);

   bullet_state_e state_reg, state_next;
   logic [9:0]    x_reg, y_reg;
   logic [3:0]    count_reg;
   logic          fired_reg;
   logic          shot_req;
   logic          move_tick;
   logic          at_top;
   logic          spawn, climb, enter_cool, count_down;

   edge_detect #(.reset_val_p(1'b1)) u_shoot_edge (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .level_i (shoot_i),
      .rise_o  (shot_req)
   );

   assign move_tick = frame_tick_i & ~freeze_i;
   // Compared at 11 bits so a large top+speed cannot wrap and let y underflow.
   assign at_top    = ({1'b0, y_reg} < ({1'b0, top_y_p} + {1'b0, speed_p}));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (shot_req && !freeze_i) state_next = ST_FLYING;
         end
         ST_FLYING: begin
            if (hit_enemy_i || (move_tick && at_top)) state_next = ST_COOLDOWN;
         end
         ST_COOLDOWN: begin
            if (count_reg == 4'd0 && !freeze_i) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (!alive_i) state_next = ST_IDLE;
   end

   always_comb begin
      bullet_active_o = (state_reg == ST_FLYING);
      state_o         = state_reg;
   end

   assign spawn      = (state_reg == ST_IDLE) && (state_next == ST_FLYING);
   assign climb      = (state_reg == ST_FLYING) && (state_next == ST_FLYING) && move_tick;
   assign enter_cool = (state_reg != ST_COOLDOWN) && (state_next == ST_COOLDOWN);
   assign count_down = (state_reg == ST_COOLDOWN) && move_tick && (count_reg != 4'd0);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         x_reg     <= '0;
         y_reg     <= '0;
         count_reg <= '0;
         fired_reg <= 1'b0;
      end else begin
         fired_reg <= spawn;
         if (spawn) begin
            x_reg <= midpoint(pos_left_i, pos_right_i);
            y_reg <= start_y_p;
         end else if (climb) begin
            y_reg <= y_reg - speed_p;
         end
         if (enter_cool) begin
            count_reg <= cooldown_p;
         end else if (count_down) begin
            count_reg <= count_reg - 4'd1;
         end
      end
   end

   assign bullet_x_o   = x_reg;
   assign bullet_y_o   = y_reg;
   assign shot_fired_o = fired_reg;
   assign color_o      = color_p;

endmodule

// File: tb/tb_player_bullet.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the bullet's rules.
module tb_player_bullet;

   localparam int START_Y  = 440;
   localparam int TOP_Y    = 16;
   localparam int SPEED    = 4;
   localparam int COOLDOWN = 8;
   localparam logic [11:0] COLOR = 12'hFF0;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       shoot = 1'b0;
   logic       alive = 1'b1;
   logic       freeze = 1'b0;
   logic       hit = 1'b0;
   logic [9:0] left = '0;
   logic [9:0] right = '0;
   logic       active, fired;
   logic [9:0] bx, by;
   logic [11:0] color;
   logic [2:0] state;

   int total = 0;
   int passed = 0;

   // Model: mode 0 = waiting to shoot, 1 = bullet in the air, 2 = cooling down.
   int m_mode, m_x, m_y, m_cnt;
   bit m_prev, m_fired;

   always #5 clk = ~clk;

   player_bullet dut (
      .clk_i           (clk),
      .reset_i         (rst),
      .frame_tick_i    (tick),
      .shoot_i         (shoot),
      .alive_i         (alive),
      .freeze_i        (freeze),
      .pos_left_i      (left),
      .pos_right_i     (right),
      .hit_enemy_i     (hit),
      .bullet_active_o (active),
      .bullet_x_o      (bx),
      .bullet_y_o      (by),
      .shot_fired_o    (fired),
      .color_o         (color),
      .state_o         (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      logic [2:0] es;
      es = (m_mode == 1) ? 3'b010 : (m_mode == 2) ? 3'b100 : 3'b001;
      check({tag, ".state"},  state,  es);
      check({tag, ".active"}, active, (m_mode == 1));
      check({tag, ".x"},      bx,     m_x);
      check({tag, ".y"},      by,     m_y);
      check({tag, ".fired"},  fired,  m_fired);
      check({tag, ".color"},  color,  COLOR);
   endtask

   task automatic model_reset();
      m_mode = 0; m_x = 0; m_y = 0; m_cnt = 0; m_fired = 0; m_prev = 1;
   endtask

   // Applies the bullet rules to the inputs present just before a clock edge.
   task automatic model_step();
      bit press;
      if (rst) begin
         model_reset();
         return;
      end
      press   = shoot && !m_prev;
      m_prev  = shoot;
      m_fired = 0;
      if (!alive) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (press && !freeze) begin
            m_mode  = 1;
            m_x     = (int'(left) + int'(right)) / 2;
            m_y     = START_Y;
            m_fired = 1;
         end
      end else if (m_mode == 1) begin
         if (hit) begin
            m_mode = 2; m_cnt = COOLDOWN;
         end else if (tick && !freeze) begin
            if (m_y < TOP_Y + SPEED) begin
               m_mode = 2; m_cnt = COOLDOWN;
            end else begin
               m_y = m_y - SPEED;
            end
         end
      end else begin
         if (!freeze) begin
            if (m_cnt == 0) m_mode = 0;
            else if (tick) m_cnt = m_cnt - 1;
         end
      end
   endtask

   task automatic step(input string tag = "cyc");
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
      if (m_fired) $display("t=%0t shot spawned x=%0d y=%0d", $time, m_x, m_y);
   endtask

   initial begin
      model_reset();
      // Reset asserted between edges with the button already held.
      #1 rst = 1'b1; shoot = 1'b1;
      #1 check_all("reset");
      repeat (3) step("in_reset");
      rst = 1'b0;
      repeat (3) step("held_after_reset");
      shoot = 1'b0;
      step("release");

      // Press at pos 300/331.
      left = 10'd300; right = 10'd331; shoot = 1'b1;
      step("press");
      check("press.x_const", bx, 315);
      check("press.y_const", by, 440);
      check("press.fired_const", fired, 1);
      step("press_held");
      check("press.pulse_one_cycle", fired, 0);
      shoot = 1'b0;
      left = 10'd0; right = 10'd50;

      // Full flight to the top and through cooldown.
      tick = 1'b1;
      repeat (106) step("flight");
      check("flight.y_top", by, 16);
      check("flight.active_top", active, 1);
      step("flight_end");
      check("flight.state_cool", state, 3'b100);
      check("flight.inactive", active, 0);
      repeat (8) step("cool");
      tick = 1'b0;
      step("cool_done");
      check("flight.state_idle", state, 3'b001);

      // Hit together with a frame tick at y=200.
      shoot = 1'b1; step("hit_spawn"); shoot = 1'b0;
      tick = 1'b1;
      repeat (60) step("hit_climb");
      check("hit.y_200", by, 200);
      hit = 1'b1;
      step("hit");
      hit = 1'b0; tick = 1'b0;
      check("hit.y_stays", by, 200);
      check("hit.state_cool", state, 3'b100);
      shoot = 1'b1;
      step("hit_shoot_in_cool");
      check("hit.no_spawn", fired, 0);
      tick = 1'b1;
      repeat (8) step("hit_cool");
      tick = 1'b0;
      repeat (3) step("held_after_cool");
      check("held.no_shot", active, 0);
      shoot = 1'b0; step("repress_release");
      shoot = 1'b1; step("repress");
      check("repress.fired", fired, 1);
      shoot = 1'b0;

      // Freeze mid-flight at y=300.
      tick = 1'b1;
      repeat (35) step("frz_climb");
      check("freeze.y_300", by, 300);
      freeze = 1'b1;
      repeat (20) step("frozen");
      check("freeze.y_held", by, 300);
      freeze = 1'b0;
      step("thaw");
      check("freeze.y_296", by, 296);

      // Player dies mid-flight.
      tick = 1'b0; alive = 1'b0;
      step("dead");
      check("dead.idle", state, 3'b001);
      check("dead.inactive", active, 0);
      alive = 1'b1;
      step("revive");

      // Widest position pair.
      left = 10'd1022; right = 10'd1023; shoot = 1'b1;
      step("edge_pos");
      check("edge_pos.x", bx, 1022);
      shoot = 1'b0;

      // Asynchronous reset between edges during flight.
      tick = 1'b1;
      repeat (5) step("pre_async");
      #2 rst = 1'b1;
      #1 model_reset();
      check_all("async_mid");
      check("async.y_cleared", by, 0);
      step("async_hold");
      rst = 1'b0; tick = 1'b0;
      step("async_release");
      check("async.no_cooldown", state, 3'b001);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         tick   = ($urandom_range(0, 2) == 0);
         shoot  = ($urandom_range(0, 2) != 0);
         alive  = ($urandom_range(0, 49) != 0);
         freeze = ($urandom_range(0, 19) == 0);
         hit    = ($urandom_range(0, 39) == 0);
         left   = 10'($urandom_range(0, 1023));
         right  = 10'($urandom_range(0, 1023));
         step("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/player_bullet.md
PLAYER_BULLET -- requirements
Module: player_bullet

Interface
REQ-001 SHALL have parameter start_y_p, default 10'd440, meaning the bullet spawn row (pixel y).
REQ-002 SHALL have parameter top_y_p, default 10'd16, meaning the topmost row the bullet may occupy.
REQ-003 SHALL have parameter speed_p, default 10'd4, meaning the pixels moved upward per frame tick.
REQ-004 SHALL have parameter cooldown_p, default 4'd8, meaning the frame ticks between bullet end and the next allowed shot.
REQ-005 SHALL have parameter color_p, default 12'b1111_1111_0000, meaning the bullet RGB444 colour, passed through to color_o.
REQ-006 clk_i  input  1  single clock; all state on its rising edge.
REQ-007 reset_i  input  1  reset, asynchronous and active-high.
REQ-008 frame_tick_i  input  1  one-cycle pulse per video frame.
REQ-009 shoot_i  input  1  raw shoot button level, already synchronised.
REQ-010 alive_i  input  1  player has lives remaining.
REQ-011 freeze_i  input  1  level paused (player hit or level beat).
REQ-012 pos_left_i  input  10  player left-most x.
REQ-013 pos_right_i  input  10  player right-most x.
REQ-014 hit_enemy_i  input  1  collision unit reports the bullet hit an enemy.
REQ-015 bullet_active_o  output  1  bullet is on screen.
REQ-016 bullet_x_o  output  10  bullet column.
REQ-017 bullet_y_o  output  10  bullet row.
REQ-018 shot_fired_o  output  1  one-cycle pulse on spawn.
REQ-019 color_o  output  12  equal to color_p.
REQ-020 state_o  output  3  present one-hot state, for debugging.

Function
REQ-021 The FSM SHALL be one-hot with states IDLE=3'b001, FLYING=3'b010 and COOLDOWN=3'b100.
REQ-022 A shot request SHALL be the rising edge of shoot_i (shoot_i high, previous sample low); holding the button SHALL fire once.
REQ-023 IDLE->FLYING SHALL occur on a shot request with alive_i=1 and freeze_i=0; otherwise the request SHALL be discarded.
REQ-024 On spawn: x SHALL be (pos_left_i+pos_right_i)>>1, computed at 11 bits with no overflow; y SHALL be start_y_p; shot_fired_o SHALL be high for exactly that cycle.
REQ-025 In FLYING, on frame_tick_i with freeze_i=0: if y < top_y_p+speed_p, the FSM SHALL go to COOLDOWN; otherwise y SHALL decrease by speed_p. y SHALL never wrap below 0.
REQ-026 In FLYING, hit_enemy_i=1 SHALL move the FSM to COOLDOWN on the next edge; it SHALL take priority over a simultaneous frame_tick_i, and y SHALL not move that cycle.
REQ-027 Entering COOLDOWN SHALL load the counter with cooldown_p.
REQ-028 In COOLDOWN, the counter SHALL decrement on frame_tick_i with freeze_i=0; at 0 the FSM SHALL go to IDLE; cooldown_p=0 SHALL mean COOLDOWN lasts exactly one cycle.
REQ-029 Shot requests in FLYING or COOLDOWN SHALL be ignored and not queued.
REQ-030 freeze_i=1 SHALL hold x, y, the counter and the state; hit_enemy_i is still honoured.
REQ-031 alive_i=0 SHALL force IDLE on the next edge from any state and clear bullet_active_o.
REQ-032 bullet_active_o SHALL be 1 only in FLYING; x and y SHALL hold their last values outside FLYING.
REQ-033 A change in player position during flight SHALL NOT move the bullet.

Reset
REQ-034 Asserting reset_i SHALL immediately force: state IDLE, bullet_active_o 0, bullet_x_o 0, bullet_y_o 0, shot_fired_o 0, counter 0.
REQ-035 The shoot edge register SHALL reset to 1, so a button held through reset does not fire.
REQ-036 Reset mid-flight SHALL abandon the bullet with no COOLDOWN.

Structure
REQ-037 The state enum, the screen constants (SCREEN_W=640, SCREEN_H=480) and the RGB444 colour type SHALL live in shared package spaceinvaders_pkg.
REQ-038 Rising-edge detection SHALL be a sub-module, edge_detect, with the reset value of its previous-sample register as a parameter.

Verification
REQ-039 Press: pos 300/331, shoot_i rises -> next cycle active=1, x=315, y=440, shot_fired_o pulses for 1 cycle.
REQ-040 Flight: 106 frame ticks after spawn -> y=16, active=1; on the 107th tick -> COOLDOWN, active=0; 8 further ticks -> IDLE.
REQ-041 Hit: hit_enemy_i and frame_tick_i in the same cycle at y=200 -> COOLDOWN, y stays 200; shoot during cooldown -> no spawn.
REQ-042 Freeze: freeze_i=1 for 20 ticks mid-flight at y=300 -> y stays 300; release -> next tick y=296.
REQ-043 Held button through reset and after cooldown -> no shot until release and re-press; alive_i=0 mid-flight -> IDLE next edge.
REQ-044 Boundary: pos 1022/1023 -> x=1022; async reset asserted between edges -> outputs cleared before the next edge.
